// File: rtl/ifetch_ot.sv
// Multi-outstanding instruction fetch unit between pcGen and the iqueue.
// Up to OT_DEPTH requests may be in flight or buffered. Responses stay paired in
// order with their fetch PC. After a flush, responses to pre-flush requests are
// counted and dropped so stale instructions never reach the iqueue.
module ifetch_ot #(
    parameter int unsigned DW       = 64,
    parameter int unsigned AW       = 64,
    parameter int unsigned OT_DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          ifu_req_kill,
    output logic          ifu_mstReq_valid,
    input  logic          ifu_mstReq_ready,
    output logic [AW-1:0] ifu_addr,
    input  logic [DW-1:0] ifu_data_r,
    input  logic          ifu_slvRsp_valid,
    input  logic [AW-1:0] fetch_addr_qout,
    output logic          pcGen_fetch_ready,
    output logic [AW-1:0] if_iq_pc,
    output logic [DW-1:0] if_iq_instr,
    output logic          if_iq_valid,
    input  logic          if_iq_ready,
    input  logic          flush
);

    localparam int unsigned CW = $clog2(OT_DEPTH + 1);
    // Array index width; pointers carry CW bits but only the low PW bits address entries.
    localparam int unsigned PW = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(DW / 8 - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(OT_DEPTH);
    localparam logic [CW-1:0] LAST_PTR   = CW'(OT_DEPTH - 1);

    // Outstanding, drop and buffered counts.
    logic [CW-1:0] o_cnt, d_cnt, b_cnt;
    logic [CW-1:0] o_nxt;

    // Pending-PC FIFO.
    logic [AW-1:0] pq [OT_DEPTH];
    logic [CW-1:0] pq_rd, pq_wr;

    // Response buffer of {pc, data}.
    logic [AW-1:0] rb_pc   [OT_DEPTH];
    logic [DW-1:0] rb_data [OT_DEPTH];
    logic [CW-1:0] rb_rd, rb_wr;

    logic credit, issue, rsp_acc, rsp_drop, rsp_keep, pop;

    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + CW'(1);
    endfunction

    // Issue/response/pop decode and next outstanding count.
    always_comb begin
        credit   = ({1'b0, o_cnt} + {1'b0, b_cnt}) < {1'b0, DEPTH_C};
        issue    = ifu_mstReq_ready & ~flush & credit;
        // A response with nothing outstanding is a protocol violation and is ignored.
        rsp_acc  = ifu_slvRsp_valid & (o_cnt != '0);
        rsp_drop = rsp_acc & ~flush & (d_cnt != '0);
        rsp_keep = rsp_acc & ~flush & (d_cnt == '0);
        pop      = (b_cnt != '0) & if_iq_ready & ~flush;
        o_nxt    = o_cnt;
        if (issue && !rsp_acc) begin
            o_nxt = o_cnt + CW'(1);
        end else if (!issue && rsp_acc) begin
            o_nxt = o_cnt - CW'(1);
        end
    end

    assign ifu_mstReq_valid  = issue;
    assign pcGen_fetch_ready = issue;
    assign ifu_req_kill      = flush;
    assign ifu_addr          = fetch_addr_qout & ALIGN_MASK;

    assign if_iq_valid = (b_cnt != '0);
    assign if_iq_pc    = rb_pc[rb_rd[PW-1:0]];
    assign if_iq_instr = rb_data[rb_rd[PW-1:0]];

    // Outstanding and drop counters; a flush marks everything still in flight as stale.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_cnt <= '0;
            d_cnt <= '0;
        end else begin
            o_cnt <= o_nxt;
            if (flush) begin
                d_cnt <= o_nxt;
            end else if (rsp_drop) begin
                d_cnt <= d_cnt - CW'(1);
            end
        end
    end

    // Pending-PC FIFO: push on issue, pop on each kept response.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pq_rd <= '0;
            pq_wr <= '0;
            for (int i = 0; i < OT_DEPTH; i++) begin
                pq[i] <= '0;
            end
        end else if (flush) begin
            pq_rd <= '0;
            pq_wr <= '0;
        end else begin
            if (issue) begin
                pq[pq_wr[PW-1:0]] <= fetch_addr_qout;
                pq_wr             <= ptr_inc(pq_wr);
            end
            if (rsp_keep) begin
                pq_rd <= ptr_inc(pq_rd);
            end
        end
    end

    // Response buffer: pair each kept response with its PC, drain on iqueue accept.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rb_rd <= '0;
            rb_wr <= '0;
            b_cnt <= '0;
            for (int i = 0; i < OT_DEPTH; i++) begin
                rb_pc[i]   <= '0;
                rb_data[i] <= '0;
            end
        end else if (flush) begin
            rb_rd <= '0;
            rb_wr <= '0;
            b_cnt <= '0;
        end else begin
            if (rsp_keep) begin
                rb_pc[rb_wr[PW-1:0]]   <= pq[pq_rd[PW-1:0]];
                rb_data[rb_wr[PW-1:0]] <= ifu_data_r;
                rb_wr                  <= ptr_inc(rb_wr);
            end
            if (pop) begin
                rb_rd <= ptr_inc(rb_rd);
            end
            if (rsp_keep && !pop) begin
                b_cnt <= b_cnt + CW'(1);
            end else if (!rsp_keep && pop) begin
                b_cnt <= b_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifetch_ot.sv
// Directed bench for ifetch_ot with default parameters (DW=64, AW=64, OT_DEPTH=4).
module tb_ifetch_ot;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ifu_req_kill;
    logic        ifu_mstReq_valid;
    logic        ifu_mstReq_ready = 1'b0;
    logic [63:0] ifu_addr;
    logic [63:0] ifu_data_r = '0;
    logic        ifu_slvRsp_valid = 1'b0;
    logic [63:0] fetch_addr_qout = '0;
    logic        pcGen_fetch_ready;
    logic [63:0] if_iq_pc;
    logic [63:0] if_iq_instr;
    logic        if_iq_valid;
    logic        if_iq_ready = 1'b0;
    logic        flush = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int tb_o    = 0;

    logic [63:0] dat [4];
    logic [63:0] pcs [4];

    ifetch_ot #(.DW(64), .AW(64), .OT_DEPTH(4)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .ifu_req_kill     (ifu_req_kill),
        .ifu_mstReq_valid (ifu_mstReq_valid),
        .ifu_mstReq_ready (ifu_mstReq_ready),
        .ifu_addr         (ifu_addr),
        .ifu_data_r       (ifu_data_r),
        .ifu_slvRsp_valid (ifu_slvRsp_valid),
        .fetch_addr_qout  (fetch_addr_qout),
        .pcGen_fetch_ready(pcGen_fetch_ready),
        .if_iq_pc         (if_iq_pc),
        .if_iq_instr      (if_iq_instr),
        .if_iq_valid      (if_iq_valid),
        .if_iq_ready      (if_iq_ready),
        .flush            (flush)
    );

    always #5 CLK = ~CLK;

    // Bus-side outstanding tracker: the bench never responds with nothing in flight.
    always @(posedge CLK) begin
        if (RST) begin
            tb_o <= 0;
        end else begin
            if (ifu_slvRsp_valid) begin
                n_tests++;
                assert (tb_o != 0) else begin
                    n_fail++;
                    $error("FAIL rsp_with_none_outstanding: outstanding %0d required >0", tb_o);
                end
            end
            tb_o <= tb_o + int'(ifu_mstReq_valid) - int'(ifu_slvRsp_valid);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_req_valid", 64'(ifu_mstReq_valid), 64'd0);
        check("rst_iq_valid", 64'(if_iq_valid), 64'd0);
        check("rst_iq_pc", if_iq_pc, 64'd0);
        check("rst_iq_instr", if_iq_instr, 64'd0);
        tick();
        RST = 1'b0;

        // 1. Basic fetch
        ifu_mstReq_ready = 1'b1;
        fetch_addr_qout  = 64'h8000_0004;
        #1;
        check("t1_req_valid", 64'(ifu_mstReq_valid), 64'd1);
        check("t1_addr_aligned", ifu_addr, 64'h8000_0000);
        check("t1_pcgen_ready", 64'(pcGen_fetch_ready), 64'd1);
        tick();
        ifu_mstReq_ready = 1'b0;
        ifu_slvRsp_valid = 1'b1;
        ifu_data_r       = 64'h1122_3344_5566_7788;
        #1;
        check("t1_iq_not_yet", 64'(if_iq_valid), 64'd0);
        tick();
        ifu_slvRsp_valid = 1'b0;
        #1;
        check("t1_iq_valid", 64'(if_iq_valid), 64'd1);
        check("t1_iq_pc", if_iq_pc, 64'h8000_0004);
        check("t1_iq_instr", if_iq_instr, 64'h1122_3344_5566_7788);
        if_iq_ready = 1'b1;
        tick();
        if_iq_ready = 1'b0;
        #1;
        check("t1_iq_drained", 64'(if_iq_valid), 64'd0);

        // 2a. Outstanding limit: four issues, then stall
        ifu_mstReq_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fetch_addr_qout = 64'(8 * k);
            #1;
            check("t2_issue_valid", 64'(ifu_mstReq_valid), 64'd1);
            check("t2_issue_addr", ifu_addr, 64'(8 * k));
            tick();
        end
        fetch_addr_qout = 64'h20;
        #1;
        check("t2_limit_stall", 64'(ifu_mstReq_valid), 64'd0);
        tick();
        #1;
        check("t2_limit_stall2", 64'(ifu_mstReq_valid), 64'd0);

        // 3. Ordering: four back-to-back responses drain with no gaps
        ifu_mstReq_ready = 1'b0;
        if_iq_ready      = 1'b1;
        dat[0] = 64'hD0D0_0000_0000_0001;
        dat[1] = 64'hD1D1_0000_0000_0002;
        dat[2] = 64'hD2D2_0000_0000_0003;
        dat[3] = 64'hD3D3_0000_0000_0004;
        pcs[0] = 64'h0;
        pcs[1] = 64'h8;
        pcs[2] = 64'h10;
        pcs[3] = 64'h18;
        for (int k = 0; k < 5; k++) begin
            ifu_slvRsp_valid = (k < 4);
            ifu_data_r       = (k < 4) ? dat[k] : 64'h0;
            #1;
            if (k == 0) begin
                check("t3_iq_empty", 64'(if_iq_valid), 64'd0);
            end else begin
                check("t3_iq_valid", 64'(if_iq_valid), 64'd1);
                check("t3_iq_pc", if_iq_pc, pcs[k-1]);
                check("t3_iq_instr", if_iq_instr, dat[k-1]);
            end
            tick();
        end
        #1;
        check("t3_iq_done", 64'(if_iq_valid), 64'd0);

        // 2b. One response frees a slot only after the entry leaves the buffer
        if_iq_ready      = 1'b0;
        ifu_mstReq_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fetch_addr_qout = 64'h20 + 64'(8 * k);
            #1;
            check("t2b_issue_valid", 64'(ifu_mstReq_valid), 64'd1);
            tick();
        end
        fetch_addr_qout  = 64'h40;
        ifu_slvRsp_valid = 1'b1;
        ifu_data_r       = 64'hE0E0_E0E0_E0E0_E0E0;
        if_iq_ready      = 1'b1;
        #1;
        check("t2b_stall_t", 64'(ifu_mstReq_valid), 64'd0);
        tick();
        ifu_slvRsp_valid = 1'b0;
        #1;
        check("t2b_stall_t1", 64'(ifu_mstReq_valid), 64'd0);
        check("t2b_iq_pc", if_iq_pc, 64'h20);
        tick();
        #1;
        check("t2b_issue_t2", 64'(ifu_mstReq_valid), 64'd1);
        check("t2b_issue_addr", ifu_addr, 64'h40);
        tick();
        ifu_mstReq_ready = 1'b0;
        if_iq_ready      = 1'b0;

        // 6. Backpressure: fill the buffer, then drain one per cycle
        ifu_mstReq_ready = 1'b1;
        fetch_addr_qout  = 64'h48;
        for (int k = 0; k < 4; k++) begin
            ifu_slvRsp_valid = 1'b1;
            ifu_data_r       = 64'hF000_0000_0000_0000 + 64'(k);
            #1;
            check("t6_full_no_issue", 64'(ifu_mstReq_valid), 64'd0);
            tick();
        end
        ifu_slvRsp_valid = 1'b0;
        if_iq_ready      = 1'b1;
        #1;
        check("t6_b4_no_issue", 64'(ifu_mstReq_valid), 64'd0);
        check("t6_head_pc", if_iq_pc, 64'h28);
        check("t6_head_instr", if_iq_instr, 64'hF000_0000_0000_0000);
        tick();
        for (int k = 1; k < 4; k++) begin
            fetch_addr_qout = 64'h48 + 64'(8 * (k - 1));
            #1;
            check("t6_resume_issue", 64'(ifu_mstReq_valid), 64'd1);
            check("t6_drain_pc", if_iq_pc, 64'h28 + 64'(8 * k));
            check("t6_drain_instr", if_iq_instr, 64'hF000_0000_0000_0000 + 64'(k));
            tick();
        end
        ifu_mstReq_ready = 1'b0;
        if_iq_ready      = 1'b0;
        #1;
        check("t6_drained", 64'(if_iq_valid), 64'd0);

        // 4. Flush with three outstanding (0x48, 0x50, 0x58)
        flush            = 1'b1;
        ifu_mstReq_ready = 1'b1;
        fetch_addr_qout  = 64'h100;
        #1;
        check("t4_no_issue_flush", 64'(ifu_mstReq_valid), 64'd0);
        check("t4_kill", 64'(ifu_req_kill), 64'd1);
        tick();
        flush = 1'b0;
        #1;
        check("t4_issue_after", 64'(ifu_mstReq_valid), 64'd1);
        check("t4_issue_addr", ifu_addr, 64'h100);
        tick();
        ifu_mstReq_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ifu_slvRsp_valid = 1'b1;
            ifu_data_r       = 64'hBAD0_0000_0000_0000 + 64'(k);
            tick();
            #1;
            check("t4_stale_dropped", 64'(if_iq_valid), 64'd0);
        end
        ifu_data_r = 64'h600D_600D_600D_600D;
        tick();
        ifu_slvRsp_valid = 1'b0;
        #1;
        check("t4_new_valid", 64'(if_iq_valid), 64'd1);
        check("t4_new_pc", if_iq_pc, 64'h100);
        check("t4_new_instr", if_iq_instr, 64'h600D_600D_600D_600D);
        if_iq_ready = 1'b1;
        tick();
        if_iq_ready = 1'b0;

        // 5. Flush colliding with a response and a pop, O=2 at the flush
        ifu_mstReq_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fetch_addr_qout = 64'h200 + 64'(8 * k);
            #1;
            check("t5_issue", 64'(ifu_mstReq_valid), 64'd1);
            tick();
        end
        ifu_mstReq_ready = 1'b0;
        ifu_slvRsp_valid = 1'b1;
        ifu_data_r       = 64'hAAAA_0000_0000_0000;
        tick();
        flush       = 1'b1;
        if_iq_ready = 1'b1;
        ifu_data_r  = 64'hAAAA_0000_0000_0001;
        #1;
        check("t5_head_before", if_iq_pc, 64'h200);
        tick();
        flush            = 1'b0;
        ifu_slvRsp_valid = 1'b0;
        ifu_mstReq_ready = 1'b1;
        fetch_addr_qout  = 64'h300;
        #1;
        check("t5_iq_cleared", 64'(if_iq_valid), 64'd0);
        check("t5_drop_count", 64'(dut.d_cnt), 64'd1);
        check("t5_issue_new", 64'(ifu_mstReq_valid), 64'd1);
        tick();
        ifu_mstReq_ready = 1'b0;
        ifu_slvRsp_valid = 1'b1;
        ifu_data_r       = 64'hAAAA_0000_0000_0002;
        tick();
        ifu_data_r = 64'hCCCC_0000_0000_0003;
        #1;
        check("t5_one_dropped", 64'(if_iq_valid), 64'd0);
        tick();
        ifu_slvRsp_valid = 1'b0;
        #1;
        check("t5_next_valid", 64'(if_iq_valid), 64'd1);
        check("t5_next_pc", if_iq_pc, 64'h300);
        check("t5_next_instr", if_iq_instr, 64'hCCCC_0000_0000_0003);
        tick();
        #1;
        check("t5_drained", 64'(if_iq_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary, failed %0d", n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ifetch_ot.md
Name: ifetch_ot

Overview:
Multi-outstanding instruction fetch unit sitting between pcGen and the iqueue. It generalises the single-request fetch stage in three ways: up to OT_DEPTH requests in flight, a parametrised fetch width and address width, and an OT_DEPTH-entry response buffer. Returned data stays paired in order with its fetch PC. After a flush, responses to pre-flush requests are counted and discarded, so stale instructions never reach the iqueue.

Parameters:
DW, 64, fetch data width in bits; power of two, ≥32.
AW, 64, address/PC width in bits.
OT_DEPTH, 4, maximum number of requests in flight plus responses buffered; ≥1.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset; asynchronous, active-high.
ifu_req_kill  out  1  advisory bus kill; equal to flush.
ifu_mstReq_valid  out  1  request issue strobe; only asserted while ifu_mstReq_ready=1.
ifu_mstReq_ready  in  1  bus can accept a request this cycle.
ifu_addr  out  AW  request address, aligned to DW/8 bytes.
ifu_data_r  in  DW  response data.
ifu_slvRsp_valid  in  1  response strobe, one per accepted request, in order.
fetch_addr_qout  in  AW  next fetch PC from pcGen.
pcGen_fetch_ready  out  1  pcGen may advance; equal to ifu_mstReq_valid.
if_iq_pc  out  AW  PC of head entry, unaligned as issued.
if_iq_instr  out  DW  data of head entry.
if_iq_valid  out  1  head entry valid.
if_iq_ready  in  1  iqueue accepts head.
flush  in  1  pipeline flush.

Behaviour:
- Bus contract: every accepted request returns exactly one response, in order, even when killed. ifu_req_kill is advisory only.
- State registers:
  - O: outstanding count (issued, not yet responded).
  - D: drop count, D≤O.
  - PQ: pending-PC FIFO, OT_DEPTH entries.
  - RB: response buffer of {pc,data}, OT_DEPTH entries, count B.
- Reset (RST=1, asynchronous): O=D=B=0, both FIFOs empty, all data registers 0. Outputs: ifu_mstReq_valid=0, if_iq_valid=0, if_iq_pc=0, if_iq_instr=0.
- Issue:
  - ifu_mstReq_valid = ifu_mstReq_ready & ~flush & (O+B < OT_DEPTH).
  - ifu_addr = fetch_addr_qout with the low log2(DW/8) bits cleared.
  - On issue, push the unaligned fetch_addr_qout into PQ; O increments next cycle.
- Response, when ifu_slvRsp_valid=1:
  - O decrements.
  - If D>0 (and no flush this cycle): D decrements, data discarded, PQ untouched.
  - Otherwise: pop PQ head as pc, push {pc, ifu_data_r} into RB.
- Latency: a response in cycle t into an empty RB gives if_iq_valid=1 in t+1. Output is driven from registers only; no combinational path from ifu_data_r.
- Output: if_iq_valid = (B≠0); if_iq_pc/if_iq_instr = RB head. Pop when if_iq_valid & if_iq_ready.
- Flush in cycle t:
  - No issue in t.
  - PQ and RB cleared; B=0 and if_iq_valid=0 from t+1.
  - D(t+1) = O(t+1), where O(t+1) accounts for any issue/response in t.
  - A response arriving in cycle t is discarded.
  - An iq pop in cycle t is void.
- Simultaneous events:
  - Issue and response in the same cycle: O unchanged; PQ push and pop both take effect.
  - Response and pop with B=OT_DEPTH cannot occur; the credit rule keeps O+B ≤ OT_DEPTH.
- Response with O=0: protocol violation; ignored, counters saturate at 0. The bench asserts it never happens.
- Counter and FIFO pointer widths are clog2(OT_DEPTH+1); pointers wrap modulo OT_DEPTH.
- RST asserted mid-operation: all state cleared immediately; D=0, so no responses are dropped afterwards. The bus is reset with the block.

Test Plan:
1. Reset/basic (DW=64): release RST, ifu_mstReq_ready=1, fetch_addr_qout=0x8000_0004 → ifu_mstReq_valid=1, ifu_addr=0x8000_0000. Respond data 0x1122_3344_5566_7788 → next cycle if_iq_valid=1, if_iq_pc=0x8000_0004, if_iq_instr=0x1122_3344_5566_7788.
2. Outstanding limit (OT_DEPTH=4): ready held, no responses → exactly 4 issues with PCs 0x0,0x8,0x10,0x18, then valid=0. With if_iq_ready=1, one response in cycle t → next issue in t+2.
3. Ordering: four responses D0..D3 back-to-back → iqueue sees (0x0,D0),(0x8,D1),(0x10,D2),(0x18,D3) in order, with no gaps when if_iq_ready=1.
4. Flush drop: 3 outstanding, pulse flush → if_iq_valid=0 next cycle. New request at 0x100 issued after flush. Three old responses → nothing delivered. Fourth response → (0x100, data) delivered.
5. Flush collision: flush in the same cycle as a response, an iq pop, and O=2 → D=1 next cycle, B=0. Exactly one further response is dropped and the following one is delivered.
6. Backpressure: if_iq_ready=0 and 4 responses buffered → B=4, no issue. Raise if_iq_ready → one entry drains per cycle, each in order, and issue resumes only once O+B<4.
